// File: rtl/mult8_seq_ctrl_pkg.sv
// mult8_seq_ctrl_pkg: shared types and constants for the shared-core 8x8 multiply sequencer
// Contents: FSM state encoding, core width, step count, per-step partial-product shift table
package mult_pkg;
    localparam int CORE_W = 4;
    localparam int NUM_STEPS = 4;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RESP = 2'd2
    } state_t;
    // step order aL*bL, aH*bL, aL*bH, aH*bH
    localparam int SHIFT [NUM_STEPS] = '{0, 4, 4, 8};
endpackage

// File: rtl/mult8_seq_ctrl_if.sv
// mult8_seq_ctrl_if: two request ports and one tagged result port of the multiply sequencer
// Ports: req0/req1 valid, ready, a, b; res valid, ready, prod, id; busy status
interface mult8_seq_ctrl_if #(parameter int DATA_W = 8);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              res_valid;
    logic              res_ready;
    logic [2*DATA_W-1:0] res_prod;
    logic              res_id;
    logic              busy;
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        input  req0_ready, req1_ready, res_valid, res_prod, res_id, busy
    );
    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        output req0_ready, req1_ready, res_valid, res_prod, res_id, busy
    );
endinterface

// File: rtl/mult4x4_core.sv
// mult4x4_core: purely combinational 4x4 unsigned array multiplier
// Ports: m multiplicand nibble, q multiplier nibble, p 8-bit product
module mult4x4_core (
    input  logic [3:0] m,
    input  logic [3:0] q,
    output logic [7:0] p
);
    // each row adds the multiplicand gated by one multiplier bit, rippling into the running sum
    always_comb begin
        p = '0;
        for (int i = 0; i < 4; i++)
            p = p + ({4'b0, m & {4{q[i]}}} << i);
    end
endmodule

// File: rtl/mult8_seq_ctrl.sv
// mult8_seq_ctrl: arbitrates two requesters onto one 4x4 core, running 8x8 multiplies in four steps
// Ports: clk, rst (sync, active-high), bus (slave side: two request ports, tagged result port, busy)
module mult8_seq_ctrl
    import mult_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter bit FAIR_RR = 1'b1
) (
    input logic clk,
    input logic rst,
    mult8_seq_ctrl_if.slave bus
);
    state_t state, state_n;
    logic [1:0] step;
    logic [DATA_W-1:0] a_r, b_r;
    logic id_r, rr_ptr, grant, accept;
    logic [2*DATA_W-1:0] acc, sum, res_prod;
    logic res_valid, res_id;
    logic [CORE_W-1:0] m, q;
    logic [2*CORE_W-1:0] p;

    // requester 1 wins when alone, or when both are valid and the pointer prefers it
    assign grant = bus.req1_valid & (~bus.req0_valid | (FAIR_RR & rr_ptr));
    assign accept = (state == S_IDLE) & (bus.req0_valid | bus.req1_valid);
    assign bus.req0_ready = (state == S_IDLE) & ~grant;
    assign bus.req1_ready = (state == S_IDLE) & grant;
    assign bus.res_valid = res_valid;
    assign bus.res_prod = res_prod;
    assign bus.res_id = res_id;
    assign bus.busy = state != S_IDLE;

    // step bit 0 picks the multiplicand nibble, step bit 1 the multiplier nibble
    assign m = step[0] ? a_r[DATA_W-1:CORE_W] : a_r[CORE_W-1:0];
    assign q = step[1] ? b_r[DATA_W-1:CORE_W] : b_r[CORE_W-1:0];
    assign sum = acc + ({{(2*DATA_W-2*CORE_W){1'b0}}, p} << SHIFT[step]);

    mult4x4_core u_core (.m(m), .q(q), .p(p));

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = accept ? S_MUL : S_IDLE;
            S_MUL:   state_n = (step == 2'(NUM_STEPS - 1)) ? S_RESP : S_MUL;
            S_RESP:  state_n = bus.res_ready ? S_IDLE : S_RESP;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (rst) state <= S_IDLE;
        else state <= state_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            step <= '0;
            acc <= '0;
            a_r <= '0;
            b_r <= '0;
            id_r <= 1'b0;
            rr_ptr <= 1'b0;
            res_valid <= 1'b0;
            res_prod <= '0;
            res_id <= 1'b0;
        end else begin
            if (accept) begin
                a_r <= grant ? bus.req1_a : bus.req0_a;
                b_r <= grant ? bus.req1_b : bus.req0_b;
                id_r <= grant;
                acc <= '0;
                step <= '0;
                if (FAIR_RR) rr_ptr <= ~grant;
            end
            if (state == S_MUL) begin
                acc <= sum;
                step <= step + 2'd1;
                if (step == 2'(NUM_STEPS - 1)) begin
                    res_prod <= sum;
                    res_valid <= 1'b1;
                    res_id <= id_r;
                end
            end
            if (state == S_RESP && bus.res_ready) res_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// tb_mult8_seq_ctrl: directed self-checking bench for the shared-core multiply sequencer
module tb_mult8_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;

    mult8_seq_ctrl_if #(.DATA_W(8)) bus ();
    mult8_seq_ctrl #(.DATA_W(8), .FAIR_RR(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit id, input bit v, input logic [7:0] a, input logic [7:0] b);
        if (id) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    task automatic send(input bit id, input logic [7:0] a, input logic [7:0] b, output bit ok);
        ok = 1'b0;
        drive(id, 1'b1, a, b);
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            ok = id ? bus.req1_ready : bus.req0_ready;
            tick();
        end
        drive(id, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic wait_res(output int c);
        c = 0;
        while (bus.res_valid !== 1'b1 && c < 40) begin
            tick();
            c++;
        end
    endtask

    task automatic take();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b1, 8'h11, 8'h22);
        drive(1, 1'b1, 8'h33, 8'h44);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0)
                begin n_bad++; $display("FAIL reset_hold cyc%0d res_valid=%b busy=%b want 0 0", i, bus.res_valid, bus.busy); end
        end
        n_cmp++;
        if (bus.res_prod !== 16'h0000 || bus.res_id !== 1'b0)
            begin n_bad++; $display("FAIL reset_regs prod=%h id=%b want 0000 0", bus.res_prod, bus.res_id); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
            begin n_bad++; $display("FAIL reset_pref r0=%b r1=%b want 1 0", bus.req0_ready, bus.req1_ready); end
        drive(0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 8'h00, 8'h00);
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0)
            begin n_bad++; $display("FAIL reset_idle busy=%b want 0", bus.busy); end
    endtask

    task automatic test_single();
        bit ok;
        int c;
        send(0, 8'hFF, 8'hFF, ok);
        n_cmp++;
        if (ok !== 1'b1 || bus.busy !== 1'b1 || bus.res_valid !== 1'b0)
            begin n_bad++; $display("FAIL single_accept ok=%b busy=%b rv=%b want 1 1 0", ok, bus.busy, bus.res_valid); end
        wait_res(c);
        n_cmp++;
        if (c !== 4)
            begin n_bad++; $display("FAIL single_latency waited=%0d want 4", c); end
        n_cmp++;
        if (bus.res_prod !== 16'hFE01 || bus.res_id !== 1'b0)
            begin n_bad++; $display("FAIL single_result prod=%h id=%b want fe01 0", bus.res_prod, bus.res_id); end
        take();
        n_cmp++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0)
            begin n_bad++; $display("FAIL single_done rv=%b busy=%b want 0 0", bus.res_valid, bus.busy); end
    endtask

    task automatic test_contention();
        bit ok, f, pid;
        int c;
        logic [15:0] exp_first, exp_second;
        for (int r = 0; r < 2; r++) begin
            pid = (r == 0);
            send(pid, 8'h80, 8'h02, ok);
            wait_res(c);
            n_cmp++;
            if (ok !== 1'b1 || bus.res_prod !== 16'h0100 || bus.res_id !== pid)
                begin n_bad++; $display("FAIL contend_pre r%0d prod=%h id=%b want 0100 %b", r, bus.res_prod, bus.res_id, pid); end
            take();
            f = (r == 1);
            exp_first = f ? 16'h3A02 : 16'h03A8;
            exp_second = f ? 16'h03A8 : 16'h3A02;
            drive(0, 1'b1, 8'h12, 8'h34);
            drive(1, 1'b1, 8'hA5, 8'h5A);
            #1;
            n_cmp++;
            if (bus.req0_ready !== !f || bus.req1_ready !== f)
                begin n_bad++; $display("FAIL contend_grant r%0d r0=%b r1=%b want %b %b", r, bus.req0_ready, bus.req1_ready, !f, f); end
            tick();
            drive(f, 1'b0, 8'h00, 8'h00);
            wait_res(c);
            n_cmp++;
            if (bus.res_prod !== exp_first || bus.res_id !== f)
                begin n_bad++; $display("FAIL contend_first r%0d prod=%h id=%b want %h %b", r, bus.res_prod, bus.res_id, exp_first, f); end
            take();
            n_cmp++;
            if ((f ? bus.req0_ready : bus.req1_ready) !== 1'b1)
                begin n_bad++; $display("FAIL contend_waiter r%0d r0=%b r1=%b", r, bus.req0_ready, bus.req1_ready); end
            tick();
            drive(!f, 1'b0, 8'h00, 8'h00);
            wait_res(c);
            n_cmp++;
            if (bus.res_prod !== exp_second || bus.res_id !== !f)
                begin n_bad++; $display("FAIL contend_second r%0d prod=%h id=%b want %h %b", r, bus.res_prod, bus.res_id, exp_second, !f); end
            take();
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int c;
        send(0, 8'h37, 8'h29, ok);
        drive(1, 1'b1, 8'h03, 8'h05);
        wait_res(c);
        n_cmp++;
        if (ok !== 1'b1 || c !== 4)
            begin n_bad++; $display("FAIL bp_latency ok=%b waited=%0d want 1 4", ok, c); end
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (bus.res_valid !== 1'b1 || bus.res_prod !== 16'h08CF || bus.res_id !== 1'b0 ||
                bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.busy !== 1'b1)
                begin n_bad++; $display("FAIL bp_hold cyc%0d rv=%b prod=%h id=%b r0=%b r1=%b busy=%b want 1 08cf 0 0 0 1",
                    i, bus.res_valid, bus.res_prod, bus.res_id, bus.req0_ready, bus.req1_ready, bus.busy); end
            tick();
        end
        take();
        n_cmp++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req1_ready !== 1'b1)
            begin n_bad++; $display("FAIL bp_release rv=%b busy=%b r1=%b want 0 0 1", bus.res_valid, bus.busy, bus.req1_ready); end
        tick();
        drive(1, 1'b0, 8'h00, 8'h00);
        wait_res(c);
        n_cmp++;
        if (bus.res_prod !== 16'h000F || bus.res_id !== 1'b1)
            begin n_bad++; $display("FAIL bp_next prod=%h id=%b want 000f 1", bus.res_prod, bus.res_id); end
        take();
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        int c;
        send(0, 8'hFF, 8'h01, ok);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (ok !== 1'b1 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0)
            begin n_bad++; $display("FAIL midrst_idle ok=%b busy=%b rv=%b want 1 0 0", ok, bus.busy, bus.res_valid); end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.res_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0)
            begin n_bad++; $display("FAIL midrst_dropped res_valid rose=%b want 0", seen); end
        send(0, 8'h0F, 8'h10, ok);
        wait_res(c);
        n_cmp++;
        if (ok !== 1'b1 || c !== 4 || bus.res_prod !== 16'h00F0 || bus.res_id !== 1'b0)
            begin n_bad++; $display("FAIL midrst_next ok=%b waited=%0d prod=%h id=%b want 1 4 00f0 0", ok, c, bus.res_prod, bus.res_id); end
        take();
    endtask

    task automatic test_sweep();
        logic [7:0] vals [8] = '{8'h00, 8'h01, 8'h0F, 8'h10, 8'h7F, 8'h80, 8'hF0, 8'hFF};
        logic [7:0] a, b;
        logic [15:0] exp;
        bit ok, id;
        int c;
        for (int k = 0; k < 104; k++) begin
            a = (k < 64) ? vals[k / 8] : 8'($urandom_range(0, 255));
            b = (k < 64) ? vals[k % 8] : 8'($urandom_range(0, 255));
            id = k[0];
            exp = {8'h00, a} * {8'h00, b};
            send(id, a, b, ok);
            wait_res(c);
            repeat ($urandom_range(0, 3)) tick();
            n_cmp++;
            if (ok !== 1'b1 || c !== 4 || bus.res_valid !== 1'b1 || bus.res_prod !== exp || bus.res_id !== id)
                begin n_bad++; $display("FAIL sweep %h*%h ok=%b waited=%0d prod=%h id=%b want %h %b", a, b, ok, c, bus.res_prod, bus.res_id, exp, id); end
            take();
        end
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
